// File: rtl/lsu_pf_pkg.sv
// Shared types and constants for the LSU stride prefetcher: stride table entry,
// generator FSM states and default geometry.
package lsu_pf_pkg;

  localparam int ADDR_W          = 32;
  localparam int TAG_W_MAX       = 40;
  localparam int DEF_NUM_ENTRIES = 16;
  localparam int DEF_LINE_SIZE   = 64;
  localparam int IDX_BITS        = $clog2(DEF_NUM_ENTRIES);
  localparam int LINE_BITS       = $clog2(DEF_LINE_SIZE);
  localparam int CONF_MAX        = 3;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } pf_state_e;

  // Tags are zero-extended to TAG_W_MAX so one struct serves every table geometry
  typedef struct packed {
    logic                     valid;
    logic [TAG_W_MAX-1:0]     tag;
    logic [ADDR_W-1:0]        last_addr;
    logic signed [ADDR_W-1:0] stride;
    logic [1:0]               conf;
  } pf_entry_t;

endpackage

// File: rtl/lsu_stride_prefetcher_if.sv
// Training (demand load) and prefetch-request channels between the LSU and the
// stride prefetcher.
interface lsu_stride_prefetcher_if
  import lsu_pf_pkg::*;
#(
  parameter int WID_BITS = 2
);
  logic                train_valid;
  logic                train_ready;
  logic [ADDR_W-1:0]   train_pc;
  logic [WID_BITS-1:0] train_wid;
  logic [ADDR_W-1:0]   train_addr;
  logic                pf_valid;
  logic                pf_ready;
  logic [ADDR_W-1:0]   pf_addr;
  logic [WID_BITS-1:0] pf_wid;
  logic [ADDR_W-1:0]   pf_pc;

  modport master (
    output train_valid, train_pc, train_wid, train_addr, pf_ready,
    input  train_ready, pf_valid, pf_addr, pf_wid, pf_pc
  );

  modport slave (
    input  train_valid, train_pc, train_wid, train_addr, pf_ready,
    output train_ready, pf_valid, pf_addr, pf_wid, pf_pc
  );
endinterface

// File: rtl/lsu_pf_fifo.sv
// Small power-of-two FIFO for prefetch requests; push is accepted when full if a
// pop happens in the same cycle. Head reads zero while empty.
module lsu_pf_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [DATAW-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lsu_stride_prefetcher.sv
// Per-(PC, warp) stride prefetcher: trains a direct-mapped stride table on accepted
// demand loads and emits DEGREE line-aligned candidates per confident trigger.
module lsu_stride_prefetcher
  import lsu_pf_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int DEGREE      = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int LINE_SIZE   = DEF_LINE_SIZE,
  parameter int CONF_THRESH = 2,
  parameter int MODE        = 0,
  parameter int WID_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  lsu_stride_prefetcher_if.slave pf_bus,
  output logic [15:0]            drop_count,
  output logic [15:0]            issue_count
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int DATAW = 2*ADDR_W + WID_BITS;

  function automatic logic [1:0] conf_inc(input logic [1:0] c);
    return (c == 2'(CONF_MAX)) ? c : c + 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_SIZE - 1);
  endfunction

  pf_entry_t                table_q [NUM_ENTRIES];
  pf_state_e                state_q, state_d;
  logic [3:0]               k_q, k_d;
  logic [ADDR_W-1:0]        cur_q, base_line_q, prev_line_q, pc_q;
  logic signed [ADDR_W-1:0] stride_q;
  logic [WID_BITS-1:0]      wid_q;

  logic [IDX_W-1:0]         idx;
  logic [TAG_W_MAX-1:0]     tag;
  pf_entry_t                rd_ent, wr_ent;
  logic signed [ADDR_W-1:0] delta, trig_stride;
  logic                     accept, hit, trigger;
  logic [ADDR_W-1:0]        cand;
  logic                     suppress, gen_push, fifo_push, fifo_full, fifo_empty, pop, drop;
  logic [DATAW-1:0]         head;

  assign pf_bus.train_ready = (state_q == IDLE);
  assign accept = pf_bus.train_valid && pf_bus.train_ready;
  assign idx    = pf_bus.train_pc[2 +: IDX_W];
  assign tag    = TAG_W_MAX'({pf_bus.train_wid, pf_bus.train_pc[ADDR_W-1:2+IDX_W]});

  // Training: look up the entry and form its post-update contents
  always_comb begin
    rd_ent           = table_q[idx];
    hit              = rd_ent.valid && (rd_ent.tag == tag);
    delta            = pf_bus.train_addr - rd_ent.last_addr;
    wr_ent.valid     = 1'b1;
    wr_ent.tag       = tag;
    wr_ent.last_addr = pf_bus.train_addr;
    wr_ent.stride    = '0;
    wr_ent.conf      = 2'd0;
    if (hit) begin
      if ((delta == rd_ent.stride) && (rd_ent.stride != 0)) begin
        wr_ent.stride = rd_ent.stride;
        wr_ent.conf   = conf_inc(rd_ent.conf);
      end else begin
        wr_ent.stride = delta;
      end
    end
    if (MODE == 1) begin
      trigger     = 1'b1;
      trig_stride = ADDR_W'(LINE_SIZE);
    end else begin
      trigger     = hit && (wr_ent.conf >= 2'(CONF_THRESH)) && (wr_ent.stride != 0);
      trig_stride = wr_ent.stride;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_q[i].valid <= 1'b0;
    end else if (accept) begin
      table_q[idx] <= wr_ent;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (accept && trigger) begin
        state_d = GEN;
        k_d     = 4'd1;
      end
      GEN: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'(DEGREE)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Generation: cur_q walks base + k*stride incrementally, one candidate per cycle
  assign cand      = line_of(cur_q);
  assign suppress  = (cand == base_line_q) || (cand == prev_line_q);
  assign pop       = !fifo_empty && pf_bus.pf_ready;
  assign gen_push  = (state_q == GEN) && !suppress && !flush;
  assign fifo_push = gen_push && (!fifo_full || pop);
  assign drop      = gen_push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (accept && trigger) begin
      base_line_q <= line_of(pf_bus.train_addr);
      prev_line_q <= line_of(pf_bus.train_addr);
      cur_q       <= pf_bus.train_addr + trig_stride;
      stride_q    <= trig_stride;
      pc_q        <= pf_bus.train_pc;
      wid_q       <= pf_bus.train_wid;
    end else begin
      if (state_q == GEN) cur_q <= cur_q + stride_q;
      if (fifo_push) prev_line_q <= cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= 4'd0;
      drop_count  <= 16'd0;
      issue_count <= 16'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (drop) drop_count <= sat_inc16(drop_count);
      if (pop)  issue_count <= sat_inc16(issue_count);
    end
  end

  lsu_pf_fifo #(
    .DATAW(DATAW),
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (fifo_push),
    .push_data({pc_q, wid_q, cand}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign pf_bus.pf_valid = !fifo_empty;
  assign {pf_bus.pf_pc, pf_bus.pf_wid, pf_bus.pf_addr} = head;

endmodule

// File: tb/tb_lsu_stride_prefetcher.sv
// Bench for lsu_stride_prefetcher: directed scenarios plus randomized training
// streams compared against a transaction-level stride-table model.
module tb_lsu_stride_prefetcher;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [1:0]  wid;
  } pf_t;

  logic        clk = 1'b0;
  logic        rst0, rst1, flush0, flush1;
  logic [15:0] drop0, issue0, drop1, issue1;

  int  n_cmp = 0;
  int  n_err = 0;
  pf_t obs0[$], obs1[$], exp0[$], exp1[$], got[$];
  int  exp_total[2];

  logic        m_valid  [2][16];
  logic [31:0] m_tag    [2][16];
  logic [31:0] m_last   [2][16];
  logic [31:0] m_stride [2][16];
  int          m_conf   [2][16];

  logic [31:0] pcs[4]     = '{32'h80000100, 32'h80000140, 32'h80000204, 32'h8000030C};
  logic [31:0] strides[5] = '{32'h40, 32'hFFFFFF80, 32'h100, 32'h4, 32'h20};
  logic [31:0] s_addr[4][2];
  logic [31:0] s_stride[4][2];

  lsu_stride_prefetcher_if #(.WID_BITS(2)) if0 ();
  lsu_stride_prefetcher_if #(.WID_BITS(2)) if1 ();

  lsu_stride_prefetcher u_dut0 (
    .clk(clk), .reset(rst0), .flush(flush0), .pf_bus(if0),
    .drop_count(drop0), .issue_count(issue0)
  );

  lsu_stride_prefetcher #(.QUEUE_DEPTH(2), .MODE(1)) u_dut1 (
    .clk(clk), .reset(rst1), .flush(flush1), .pf_bus(if1),
    .drop_count(drop1), .issue_count(issue1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if0.pf_valid && if0.pf_ready) obs0.push_back({if0.pf_addr, if0.pf_pc, if0.pf_wid});
    if (if1.pf_valid && if1.pf_ready) obs1.push_back({if1.pf_addr, if1.pf_pc, if1.pf_wid});
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear(input int sel, input bit clr_total);
    for (int i = 0; i < 16; i++) m_valid[sel][i] = 1'b0;
    if (sel == 0) begin
      exp_total[0] -= exp0.size();
      exp0.delete();
    end else begin
      exp_total[1] -= exp1.size();
      exp1.delete();
    end
    if (clr_total) exp_total[sel] = 0;
  endfunction

  // Spec-level model: table rules, then DEGREE=2 candidates with line suppression
  function automatic void model_train(input int sel, input logic [31:0] pc,
                                      input logic [1:0] wid, input logic [31:0] addr);
    int          idx;
    logic [31:0] tag, stride, base, cand, prev, delta;
    bit          trig;
    idx    = int'(pc[5:2]);
    tag    = {4'd0, wid, pc[31:6]};
    stride = 32'd0;
    trig   = 1'b0;
    if (m_valid[sel][idx] && m_tag[sel][idx] == tag) begin
      delta = addr - m_last[sel][idx];
      if (delta == m_stride[sel][idx] && m_stride[sel][idx] != 0)
        m_conf[sel][idx] = (m_conf[sel][idx] == 3) ? 3 : m_conf[sel][idx] + 1;
      else begin
        m_stride[sel][idx] = delta;
        m_conf[sel][idx]   = 0;
      end
      m_last[sel][idx] = addr;
      stride = m_stride[sel][idx];
      trig   = (m_conf[sel][idx] >= 2) && (stride != 0);
    end else begin
      m_valid[sel][idx]  = 1'b1;
      m_tag[sel][idx]    = tag;
      m_last[sel][idx]   = addr;
      m_stride[sel][idx] = 32'd0;
      m_conf[sel][idx]   = 0;
    end
    if (sel == 1) begin
      trig   = 1'b1;
      stride = 32'd64;
    end
    if (trig) begin
      base = addr & ~32'h3F;
      prev = base;
      for (int k = 1; k <= 2; k++) begin
        cand = (addr + 32'(k) * stride) & ~32'h3F;
        if (cand != base && cand != prev) begin
          if (sel == 0) exp0.push_back({cand, pc, wid});
          else          exp1.push_back({cand, pc, wid});
          exp_total[sel]++;
          prev = cand;
        end
      end
    end
  endfunction

  task automatic train(input int sel, input logic [31:0] pc, input logic [1:0] wid,
                       input logic [31:0] addr, input bit use_model);
    int guard;
    guard = 0;
    while (((sel == 0) ? if0.train_ready : if1.train_ready) !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    chk("train_ready_wait", 32'(guard < 50), 32'd1);
    if (sel == 0) begin
      if0.train_valid = 1'b1; if0.train_pc = pc; if0.train_wid = wid; if0.train_addr = addr;
    end else begin
      if1.train_valid = 1'b1; if1.train_pc = pc; if1.train_wid = wid; if1.train_addr = addr;
    end
    step();
    if0.train_valid = 1'b0;
    if1.train_valid = 1'b0;
    if (use_model) model_train(sel, pc, wid, addr);
  endtask

  task automatic drain(input int sel, input int cycles);
    if (sel == 0) if0.pf_ready = 1'b1;
    else          if1.pf_ready = 1'b1;
    repeat (cycles) step();
  endtask

  task automatic cmp_model(input int sel);
    pf_t o[$], e[$], g;
    if (sel == 0) begin o = obs0; e = exp0; obs0.delete(); exp0.delete(); end
    else          begin o = obs1; e = exp1; obs1.delete(); exp1.delete(); end
    chk("pf_count", 32'(o.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      g = (i < o.size()) ? o[i] : '0;
      chk("pf_addr", g.addr, e[i].addr);
      chk("pf_pc", g.pc, e[i].pc);
      chk("pf_wid", 32'(g.wid), 32'(e[i].wid));
    end
    got = o;
  endtask

  initial begin
    int s, w;
    exp_total[0] = 0;
    exp_total[1] = 0;
    rst0 = 1'b1; rst1 = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
    if0.train_valid = 1'b0; if0.train_pc = '0; if0.train_wid = '0; if0.train_addr = '0;
    if1.train_valid = 1'b0; if1.train_pc = '0; if1.train_wid = '0; if1.train_addr = '0;
    if0.pf_ready = 1'b1; if1.pf_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin m_valid[0][i] = 1'b0; m_valid[1][i] = 1'b0; end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        s_addr[i][j] = 32'h10000 * (i * 2 + j + 1);
        s_stride[i][j] = 32'h40;
      end
    end
    step(); step();
    rst0 = 1'b0; rst1 = 1'b0;

    // Reset state
    chk("rst_pf_valid", 32'(if0.pf_valid), 32'd0);
    chk("rst_pf_addr", if0.pf_addr, 32'd0);
    chk("rst_pf_pc", if0.pf_pc, 32'd0);
    chk("rst_pf_wid", 32'(if0.pf_wid), 32'd0);
    chk("rst_drop", 32'(drop0), 32'd0);
    chk("rst_issue", 32'(issue0), 32'd0);
    chk("rst_train_ready", 32'(if0.train_ready), 32'd1);
    chk("rst1_pf_valid", 32'(if1.pf_valid), 32'd0);

    // Positive stride 0x100: trigger on the fourth load, one-cycle push latency
    train(0, 32'h80000100, 2'd0, 32'h1000, 1);
    train(0, 32'h80000100, 2'd0, 32'h1100, 1);
    train(0, 32'h80000100, 2'd0, 32'h1200, 1);
    drain(0, 4);
    chk("tp1_no_pf_early", 32'(obs0.size()), 32'd0);
    train(0, 32'h80000100, 2'd0, 32'h1300, 1);
    chk("tp1_lat_e0_valid", 32'(if0.pf_valid), 32'd0);
    step();
    chk("tp1_lat_e1_valid", 32'(if0.pf_valid), 32'd1);
    chk("tp1_lat_e1_addr", if0.pf_addr, 32'h1400);
    drain(0, 5);
    cmp_model(0);
    chk("tp1_addr0", got[0].addr, 32'h1400);
    chk("tp1_addr1", got[1].addr, 32'h1500);
    chk("tp1_pc1", got[1].pc, 32'h80000100);
    chk("tp1_issue", 32'(issue0), 32'd2);

    // Negative stride
    train(0, 32'h80000204, 2'd0, 32'h2000, 1);
    train(0, 32'h80000204, 2'd0, 32'h1FC0, 1);
    train(0, 32'h80000204, 2'd0, 32'h1F80, 1);
    train(0, 32'h80000204, 2'd0, 32'h1F40, 1);
    drain(0, 6);
    cmp_model(0);
    chk("neg_addr0", got[0].addr, 32'h1F00);
    chk("neg_addr1", got[1].addr, 32'h1EC0);

    // Stride 4 stays inside the base line: everything suppressed, nothing dropped
    train(0, 32'h80000308, 2'd0, 32'h0, 1);
    train(0, 32'h80000308, 2'd0, 32'h4, 1);
    train(0, 32'h80000308, 2'd0, 32'h8, 1);
    train(0, 32'h80000308, 2'd0, 32'hC, 1);
    for (int i = 0; i < 4; i++) begin
      chk("small_no_valid", 32'(if0.pf_valid), 32'd0);
      step();
    end
    cmp_model(0);
    chk("small_drop", 32'(drop0), 32'd0);

    // Same index, different warp: tag miss and reallocation
    train(0, 32'h80000100, 2'd1, 32'h1400, 1);
    train(0, 32'h80000100, 2'd0, 32'h1400, 1);
    drain(0, 5);
    cmp_model(0);
    chk("alias_no_pf", 32'(got.size()), 32'd0);

    // Randomized training streams against the model
    for (int n = 0; n < 80; n++) begin
      s = $urandom_range(0, 3);
      w = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) s_stride[s][w] = strides[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) s_addr[s][w] = $urandom;
      else                           s_addr[s][w] = s_addr[s][w] + s_stride[s][w];
      train(0, pcs[s], 2'(w), s_addr[s][w], 1);
      repeat ($urandom_range(0, 2)) step();
    end
    drain(0, 8);
    cmp_model(0);
    chk("rand_issue", 32'(issue0), 32'(exp_total[0]));
    chk("rand_drop", 32'(drop0), 32'd0);

    // Next-line mode on the second instance
    train(1, 32'h80000010, 2'd1, 32'h1004, 1);
    drain(1, 6);
    cmp_model(1);
    chk("nl_addr0", got[0].addr, 32'h1040);
    chk("nl_addr1", got[1].addr, 32'h1080);
    chk("nl_wid", 32'(got[0].wid), 32'd1);

    // Two-entry queue, stalled arbiter: second trigger's candidates are dropped
    if1.pf_ready = 1'b0;
    train(1, 32'h80000010, 2'd0, 32'h1000, 0);
    train(1, 32'h80000010, 2'd0, 32'h3000, 0);
    repeat (4) step();
    chk("full_drop", 32'(drop1), 32'd2);
    chk("full_head_valid", 32'(if1.pf_valid), 32'd1);
    chk("full_head_addr", if1.pf_addr, 32'h1040);
    drain(1, 5);
    chk("full_drain_n", 32'(obs1.size()), 32'd2);
    got = obs1;
    obs1.delete();
    chk("full_drain0", got[0].addr, 32'h1040);
    chk("full_drain1", got[1].addr, 32'h1080);
    chk("full_issue", 32'(issue1), 32'd4);

    // Flush in the second GEN cycle with one queued entry
    if0.pf_ready = 1'b0;
    train(0, 32'h80000038, 2'd0, 32'h5000, 1);
    train(0, 32'h80000038, 2'd0, 32'h5100, 1);
    train(0, 32'h80000038, 2'd0, 32'h5200, 1);
    train(0, 32'h80000038, 2'd0, 32'h5300, 1);
    step();
    chk("fl_pre_valid", 32'(if0.pf_valid), 32'd1);
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    model_clear(0, 1'b0);
    chk("fl_valid", 32'(if0.pf_valid), 32'd0);
    repeat (3) step();
    chk("fl_no_more_push", 32'(if0.pf_valid), 32'd0);
    chk("fl_issue_kept", 32'(issue0), 32'(exp_total[0]));
    chk("fl_drop_kept", 32'(drop0), 32'd0);
    if0.pf_ready = 1'b1;
    train(0, 32'h80000038, 2'd0, 32'h5400, 1);
    train(0, 32'h80000038, 2'd0, 32'h5500, 1);
    train(0, 32'h80000038, 2'd0, 32'h5600, 1);
    drain(0, 4);
    chk("fl_retrain_quiet", 32'(obs0.size()), 32'd0);
    train(0, 32'h80000038, 2'd0, 32'h5700, 1);
    drain(0, 6);
    cmp_model(0);
    chk("fl_retrain_addr", got[0].addr, 32'h5800);

    // Reset in the second GEN cycle: counters cleared as well
    if0.pf_ready = 1'b0;
    train(0, 32'h80000038, 2'd0, 32'h5800, 1);
    step();
    chk("rs_pre_valid", 32'(if0.pf_valid), 32'd1);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    model_clear(0, 1'b1);
    chk("rs_valid", 32'(if0.pf_valid), 32'd0);
    chk("rs_addr", if0.pf_addr, 32'd0);
    chk("rs_issue", 32'(issue0), 32'd0);
    chk("rs_drop", 32'(drop0), 32'd0);
    chk("rs_train_ready", 32'(if0.train_ready), 32'd1);
    repeat (3) step();
    chk("rs_no_more_push", 32'(if0.pf_valid), 32'd0);
    if0.pf_ready = 1'b1;
    train(0, 32'h80000038, 2'd0, 32'h5900, 1);
    drain(0, 5);
    cmp_model(0);
    chk("rs_table_cleared", 32'(got.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_stride_prefetcher.md
Name: lsu_stride_prefetcher

Overview:
- Per-(PC, warp) stride prefetch engine for the LSU. It generalises the fixed next-line prefetch into a trained, confidence-gated generator with a configurable table, degree and mode.
- It observes accepted demand loads (leader-thread address), trains a direct-mapped stride table, and emits line-aligned prefetch addresses.
- Addresses are queued in a small FIFO toward the LSU request arbiter, which issues them to the dcache at lower priority than demand requests.

Parameters:
- NUM_ENTRIES, 16, stride table entries; power of 2, minimum 2.
- DEGREE, 2, prefetch candidates generated per trigger, 1..8.
- QUEUE_DEPTH, 4, output FIFO depth; power of 2, minimum 2.
- LINE_SIZE, 64, dcache line size in bytes; power of 2.
- CONF_THRESH, 2, confidence needed to trigger, 1..3.
- MODE, 0, 0 = stride, 1 = next-line (stride forced to +LINE_SIZE, confidence ignored).
- WID_BITS, 2, warp id width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  clear table, FSM and FIFO.
- train_valid  in  1  demand load accepted by the LSU.
- train_ready  out  1  trainer can accept a load.
- train_pc  in  32  load PC.
- train_wid  in  WID_BITS  warp id.
- train_addr  in  32  leader-thread byte address.
- pf_valid  out  1  prefetch request available.
- pf_ready  in  1  arbiter takes the request.
- pf_addr  out  32  line-aligned byte address.
- pf_wid  out  WID_BITS  warp id of the triggering load.
- pf_pc  out  32  PC of the triggering load.
- drop_count  out  16  saturating count of candidates dropped on a full FIFO.
- issue_count  out  16  saturating count of pf handshakes.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - All table valid bits cleared, FSM set to IDLE, FIFO emptied.
  - pf_valid=0; pf_addr, pf_wid and pf_pc read 0.
  - drop_count=0, issue_count=0; train_ready=1 from the first cycle after reset.
- Table indexing:
  - Index = train_pc[2 +: log2(NUM_ENTRIES)].
  - Tag = {train_wid, train_pc[31:2+log2(NUM_ENTRIES)]}.
  - Entry fields: valid, tag, last_addr[31:0], stride[31:0] (two's complement), conf[1:0].
- Training is performed at an accept edge (train_valid && train_ready). Let delta = train_addr - last_addr, computed mod 2^32.
  - Miss (invalid entry or tag mismatch): allocate the entry with last_addr=train_addr, stride=0, conf=0. Never triggers.
  - Hit, delta==stride and stride!=0: conf saturates up to 3.
  - Hit, otherwise: stride=delta, conf=0.
  - On every hit, last_addr=train_addr.
- Trigger condition: post-update conf >= CONF_THRESH and stride != 0.
  - In MODE=1, every accepted load triggers, with stride = +LINE_SIZE.
  - On trigger, base=train_addr, stride, wid and pc are latched.
- FSM is IDLE -> GEN -> IDLE.
  - train_ready = (state==IDLE).
  - Trigger at an accept edge moves the FSM to GEN with k=1.
  - GEN lasts exactly DEGREE cycles; k increments each cycle, and the FSM returns to IDLE after k==DEGREE.
- Candidate generation in GEN:
  - cand = base + k*stride (mod 2^32), with the low log2(LINE_SIZE) bits zeroed.
  - Suppress when cand equals the line of base or the previously pushed candidate's line. A suppressed candidate is not counted as a drop.
  - Otherwise push into the FIFO. If the FIFO is full and there is no pop in the same cycle, drop the candidate and increment drop_count (saturating at 0xFFFF).
- FIFO behaviour:
  - pf_* is the FIFO head; pf_valid = !empty.
  - Push and pop in the same cycle are allowed at any fill level, including full.
  - The head is held stable while pf_valid && !pf_ready.
  - issue_count increments on pf_valid && pf_ready.
- Latency: accept edge E0 -> first push at E1 -> pf_valid high in the cycle after E1.
- flush: takes effect at the next edge, with the same effect as reset except that the counters are kept. Flush has priority over a train accept or push in the same cycle.
- Reset or flush during GEN: the generation is aborted and no further pushes occur.

Decomposition:
- Shared package lsu_pf_pkg:
  - pf_entry_t struct (valid, tag, last_addr, stride, conf).
  - pf_state_e enum (IDLE, GEN).
  - Constants IDX_BITS, LINE_BITS, CONF_MAX=3.
- One sub-module lsu_pf_fifo:
  - Parametrised DATAW and DEPTH.
  - Ports push, pop, full, empty and head data.
  - Synchronous reset and flush.

Test Plan:
- MODE=0, DEGREE=2, CONF_THRESH=2, LINE_SIZE=64. Train pc=0x80000100, wid=0 with addr 0x1000, 0x1100, 0x1200, 0x1300, pf_ready=1 -> no pf output after the first three loads. After the fourth, pf_addr=0x1400 then 0x1500, both with pf_pc=0x80000100; issue_count=2.
- Negative stride: addr 0x2000, 0x1FC0, 0x1F80, 0x1F40 -> pf_addr=0x1F00, then 0x1EC0.
- Small stride: addr 0x0, 0x4, 0x8, 0xC -> candidates 0x10 and 0x14 lie in line 0x0 and are suppressed. No pf_valid; drop_count stays 0.
- QUEUE_DEPTH=2, pf_ready=0, two triggers of DEGREE=2 -> FIFO holds 2 entries, drop_count=2. Raise pf_ready -> the two oldest addresses drain in order.
- Aliasing: same PC index with a different wid -> tag miss and reallocation with conf=0, no trigger. MODE=1 with a single load at addr 0x1004 -> pf_addr=0x1040, then 0x1080.
- Assert flush, then separately reset, in the second GEN cycle with FIFO occupancy 1 -> pf_valid=0 next cycle and the table is cleared (a re-trained stride needs the full threshold again). After flush drop_count and issue_count are retained; after reset they read 0.
